// File: rtl/ip_decoder_pkg.sv
// Shared IPv4 receive/transmit definitions: header layout, error codes, FSM states and
// the ones-complement add used by the checksum accumulator.
package ip_decoder_pkg;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [3:0]  IPV4_IHL     = 4'd5;
  localparam logic [15:0] IPH_LEN      = 16'd20;
  localparam logic [4:0]  IPH_LAST_IDX = 5'd19;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_VER   = 3'd1,
    ERR_CSUM  = 3'd2,
    ERR_LEN   = 3'd3,
    ERR_PROTO = 3'd4,
    ERR_DADDR = 3'd5,
    ERR_TRUNC = 3'd6,
    ERR_FRAG  = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_CHECK,
    ST_SEG,
    ST_DROP
  } state_e;

  // Wire order of the 20-byte header; byte 0 lands in the top bits.
  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] ident;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] csum;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } ipv4_hdr_t;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_decoder_if.sv
// Byte stream with valid/ready/last; master drives data, slave returns ready.
interface ip_decoder_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/ip_csum_acc.sv
// Ones-complement 16-bit accumulator with end-around carry folded on every add.
module ip_csum_acc
  import ip_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sum <= '0;
    else if (clear) sum <= '0;
    else if (en)    sum <= ones_add(sum, word);
  end

endmodule

// File: rtl/ip_decoder.sv
// Receive-side IPv4 layer: validates the 20-byte header, strips it and forwards the TCP
// segment through a single output register.
module ip_decoder
  import ip_decoder_pkg::*;
#(
  parameter logic [7:0]  PROTOCOL  = 8'd6,
  parameter logic [31:0] LOCALADDR = 32'h7f00_0001,
  parameter int unsigned MAX_LEN   = 302
) (
  input  logic         clk,
  input  logic         rst_n,
  ip_decoder_if.slave  s,
  ip_decoder_if.master m,
  output logic         hdr_valid,
  output logic [31:0]  hdr_src_addr,
  output logic [15:0]  hdr_ident,
  output logic [15:0]  hdr_seg_len,
  output logic         err_valid,
  output err_code_e    err_code
);

  localparam logic [15:0] MAX_LEN_W = MAX_LEN[15:0];

  state_e      state_q, state_d;
  ipv4_hdr_t   hdr_q;
  logic [4:0]  idx_q;
  logic [15:0] rem_q;
  logic        last19_q;
  logic        rdy_en_q;
  logic [7:0]  m_data_q;
  logic        m_valid_q, m_last_q;
  logic [15:0] csum;
  logic        s_rdy, take;
  logic        csum_clear, csum_en;
  err_code_e   chk_code;

  logic unused_hdr;
  assign unused_hdr = ^{hdr_q.tos, hdr_q.ttl, hdr_q.csum, hdr_q.flags[2:1]};

  assign take       = s.valid & s_rdy;
  assign csum_clear = (state_q == ST_HDR) && (idx_q == '0);
  // Odd header bytes complete a big-endian word with the byte shifted in just before.
  assign csum_en    = (state_q == ST_HDR) && take && idx_q[0];

  ip_csum_acc u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (csum_clear),
    .en    (csum_en),
    .word  ({hdr_q.dst_addr[7:0], s.data}),
    .sum   (csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    state_d  = state_q;
    s_rdy    = 1'b0;
    chk_code = ERR_NONE;

    if (hdr_q.version != IPV4_VERSION || hdr_q.ihl != IPV4_IHL)  chk_code = ERR_VER;
    else if (csum != 16'hFFFF)                                     chk_code = ERR_CSUM;
    else if (hdr_q.total_len < IPH_LEN || hdr_q.total_len > MAX_LEN_W) chk_code = ERR_LEN;
    else if (hdr_q.flags[0] || hdr_q.frag_off != '0)               chk_code = ERR_FRAG;
    else if (hdr_q.protocol != PROTOCOL)                           chk_code = ERR_PROTO;
    else if (hdr_q.dst_addr != LOCALADDR)                          chk_code = ERR_DADDR;
    else if (last19_q && hdr_q.total_len != IPH_LEN)               chk_code = ERR_TRUNC;

    unique case (state_q)
      ST_HDR: begin
        s_rdy = rdy_en_q;
        if (s.valid && s_rdy && idx_q == IPH_LAST_IDX) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk_code != ERR_NONE || hdr_q.total_len == IPH_LEN)
          state_d = last19_q ? ST_HDR : ST_DROP;
        else
          state_d = ST_SEG;
      end
      ST_SEG: begin
        s_rdy = ~m_valid_q | m.ready;
        if (s.valid && s_rdy && (s.last || rem_q == 16'd1))
          state_d = s.last ? ST_HDR : ST_DROP;
      end
      ST_DROP: begin
        s_rdy = rdy_en_q;
        if (s.valid && s_rdy && s.last) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the header shift register is reset with everything else; it is small and keeps
    // the checks in CHECK free of X after power-up.
    if (!rst_n) begin
      hdr_q        <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      last19_q     <= 1'b0;
      rdy_en_q     <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      hdr_valid    <= 1'b0;
      hdr_src_addr <= '0;
      hdr_ident    <= '0;
      hdr_seg_len  <= '0;
      err_valid    <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      rdy_en_q  <= 1'b1;
      hdr_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      // The output register drains in any state, so the next header can overlap it.
      if (m_valid_q && m.ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      case (state_q)
        ST_HDR: if (take) begin
          hdr_q <= {hdr_q[151:0], s.data};
          if (idx_q == IPH_LAST_IDX) begin
            idx_q    <= '0;
            last19_q <= s.last;
          end else if (s.last) begin
            idx_q     <= '0;
            err_valid <= 1'b1;
            err_code  <= ERR_TRUNC;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ST_CHECK: begin
          if (chk_code != ERR_NONE) begin
            err_valid <= 1'b1;
            err_code  <= chk_code;
          end else begin
            hdr_valid    <= 1'b1;
            hdr_src_addr <= hdr_q.src_addr;
            hdr_ident    <= hdr_q.ident;
            hdr_seg_len  <= hdr_q.total_len - IPH_LEN;
            rem_q        <= hdr_q.total_len - IPH_LEN;
          end
        end
        ST_SEG: if (take) begin
          m_data_q  <= s.data;
          m_valid_q <= 1'b1;
          m_last_q  <= (rem_q == 16'd1) | s.last;
          rem_q     <= rem_q - 16'd1;
          if (s.last && rem_q != 16'd1) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TRUNC;
          end
        end
        default: ;
      endcase
    end
  end

  assign s.ready = s_rdy;
  assign m.data  = m_data_q;
  assign m.valid = m_valid_q;
  assign m.last  = m_last_q;

endmodule
